// File: rtl/imem_fetch_pipe.sv
// Instruction memory behind a LAT-stage fetch pipeline with backpressure, flush,
// a program-load write port, and accept/fault counters.
module imem_fetch_pipe #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned LAT   = 2,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_pc,
    output logic [1:0]  rsp_fault,
    input  logic        flush,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic [31:0] fetch_count,
    output logic [15:0] fault_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    // Unloaded words read back as the filler instruction; reset leaves them alone.
    logic [31:0] mem [DEPTH] = '{default: NOP};

    logic        adv;
    logic        accept;
    logic        load_ok;
    logic [1:0]  req_fault;
    logic [31:0] head_instr;

    logic        valid_reg [LAT];
    logic [31:0] pc_reg    [LAT];
    logic [31:0] instr_reg [LAT];
    logic [1:0]  fault_reg [LAT];

    logic [31:0] fetch_count_reg;
    logic [15:0] fault_count_reg;

    assign rsp_valid = valid_reg[LAT-1];
    assign rsp_pc    = pc_reg[LAT-1];
    assign rsp_instr = instr_reg[LAT-1];
    assign rsp_fault = fault_reg[LAT-1];

    assign adv       = !rsp_valid || rsp_ready;
    assign req_ready = rst_n && adv && !flush && !load_en;
    assign accept    = req_valid && req_ready;

    always_comb begin
        req_fault = FAULT_OK;
        if (req_pc[1:0] != 2'b00) begin
            req_fault = FAULT_MISALIGN;
        end else if (req_pc[31:AW+2] != '0) begin
            req_fault = FAULT_RANGE;
        end
    end

    assign head_instr = (req_fault == FAULT_OK) ? mem[req_pc[AW+1:2]] : NOP;
    assign load_ok    = load_en && (load_addr[1:0] == 2'b00) && (load_addr[31:AW+2] == '0);

    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_addr[AW+1:2]] <= load_data;
        end
    end

    // The head stage is the registered memory read; all stages move in lockstep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LAT); i++) begin
                valid_reg[i] <= 1'b0;
                pc_reg[i]    <= '0;
                instr_reg[i] <= '0;
                fault_reg[i] <= FAULT_OK;
            end
        end else if (flush) begin
            for (int i = 0; i < int'(LAT); i++) begin
                valid_reg[i] <= 1'b0;
            end
        end else if (adv) begin
            valid_reg[0] <= accept;
            pc_reg[0]    <= req_pc;
            instr_reg[0] <= head_instr;
            fault_reg[0] <= req_fault;
            for (int i = 1; i < int'(LAT); i++) begin
                valid_reg[i] <= valid_reg[i-1];
                pc_reg[i]    <= pc_reg[i-1];
                instr_reg[i] <= instr_reg[i-1];
                fault_reg[i] <= fault_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count_reg <= '0;
            fault_count_reg <= '0;
        end else if (accept) begin
            fetch_count_reg <= fetch_count_reg + 32'd1;
            if (req_fault != FAULT_OK && fault_count_reg != 16'hFFFF) begin
                fault_count_reg <= fault_count_reg + 16'd1;
            end
        end
    end

    assign fetch_count = fetch_count_reg;
    assign fault_count = fault_count_reg;

endmodule

// File: tb/tb_imem_fetch_pipe.sv
// Self-checking bench for imem_fetch_pipe: directed scenarios plus a randomized run
// compared against a transaction-level model (queue of in-flight fetches with ages).
module tb_imem_fetch_pipe;
    localparam int DEPTH = 64;
    localparam int LAT   = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_pc;
    logic [1:0]  rsp_fault;
    logic        flush;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic [31:0] fetch_count;
    logic [15:0] fault_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  fault;
        int          age;
    } entry_t;

    entry_t      q[$];
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_fc;
    logic [15:0] m_flc;

    always #5 clk = ~clk;

    imem_fetch_pipe #(.DEPTH(DEPTH), .LAT(LAT), .NOP(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_pc(rsp_pc), .rsp_fault(rsp_fault),
        .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .fetch_count(fetch_count), .fault_count(fault_count)
    );

    function automatic logic [1:0] fault_of(input logic [31:0] a);
        if (a % 32'd4 != 32'd0) return 2'd1;
        if (a >= 32'(DEPTH * 4)) return 2'd2;
        return 2'd0;
    endfunction

    // An entry reaches the output after LAT-1 advancing edges following its accept.
    function automatic logic exp_rsp_valid();
        return (q.size() > 0) && (q[0].age == LAT - 1);
    endfunction

    function automatic logic exp_ready();
        return rst_n && (!exp_rsp_valid() || rsp_ready) && !flush && !load_en;
    endfunction

    task automatic step();
        logic   vout, adv, acc;
        entry_t e;
        vout    = exp_rsp_valid();
        adv     = !vout || rsp_ready;
        acc     = req_valid && exp_ready();
        e.pc    = req_pc;
        e.fault = fault_of(req_pc);
        e.instr = NOP;
        if (e.fault == 2'd0) e.instr = m_mem[int'(req_pc >> 2)];
        e.age   = 0;
        if (load_en && fault_of(load_addr) == 2'd0) m_mem[int'(load_addr >> 2)] = load_data;
        if (!rst_n) begin
            q.delete();
            m_fc  = '0;
            m_flc = '0;
        end else begin
            if (acc) begin
                m_fc = m_fc + 32'd1;
                if (e.fault != 2'd0 && m_flc != 16'hFFFF) m_flc = m_flc + 16'd1;
            end
            if (flush) begin
                q.delete();
            end else if (adv) begin
                if (vout) begin
                    $display("txn pc=%h instr=%h fault=%0d", q[0].pc, q[0].instr, q[0].fault);
                    void'(q.pop_front());
                end
                foreach (q[i]) q[i].age = q[i].age + 1;
                if (acc) q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b1; flush = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0; req_valid = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        step(); step();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready2: got %b want 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_instr !== 32'h0) begin errors++; $display("FAIL reset_rsp_instr: got %h want 0", rsp_instr); end
        checks++; if (rsp_pc !== 32'h0) begin errors++; $display("FAIL reset_rsp_pc: got %h want 0", rsp_pc); end
        checks++; if (rsp_fault !== 2'b00) begin errors++; $display("FAIL reset_rsp_fault: got %b want 00", rsp_fault); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_fetch_count: got %0d want 0", fetch_count); end
        checks++; if (fault_count !== 16'h0) begin errors++; $display("FAIL reset_fault_count: got %0d want 0", fault_count); end
        req_valid = 1'b0; rst_n = 1'b1;
        step();
    endtask

    task automatic test_load_fetch();
        idle();
        load_en = 1'b1; load_addr = 32'h0; load_data = 32'h00500093;
        step();
        load_en = 1'b0; req_valid = 1'b1; req_pc = 32'h0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL lf_ready: got %b want 1", req_ready); end
        step();
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lf_early: got rsp_valid=%b want 0", rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL lf_valid: got %b want 1", rsp_valid); end
        checks++; if (rsp_instr !== 32'h00500093) begin errors++; $display("FAIL lf_instr: got %h want 00500093", rsp_instr); end
        checks++; if (rsp_pc !== 32'h0) begin errors++; $display("FAIL lf_pc: got %h want 0", rsp_pc); end
        checks++; if (rsp_fault !== 2'b00) begin errors++; $display("FAIL lf_fault: got %b want 00", rsp_fault); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lf_drain: got rsp_valid=%b want 0", rsp_valid); end
    endtask

    task automatic test_faults();
        idle();
        req_valid = 1'b1; req_pc = 32'h2;
        step();
        req_pc = 32'h100;
        step();
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_pc !== 32'h2) begin errors++; $display("FAIL mis_rsp: got valid=%b pc=%h want 1/00000002", rsp_valid, rsp_pc); end
        checks++; if (rsp_fault !== 2'b01) begin errors++; $display("FAIL mis_fault: got %b want 01", rsp_fault); end
        checks++; if (rsp_instr !== NOP) begin errors++; $display("FAIL mis_instr: got %h want %h", rsp_instr, NOP); end
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_pc !== 32'h100) begin errors++; $display("FAIL oor_rsp: got valid=%b pc=%h want 1/00000100", rsp_valid, rsp_pc); end
        checks++; if (rsp_fault !== 2'b10) begin errors++; $display("FAIL oor_fault: got %b want 10", rsp_fault); end
        checks++; if (rsp_instr !== NOP) begin errors++; $display("FAIL oor_instr: got %h want %h", rsp_instr, NOP); end
        checks++; if (fault_count !== 16'd2) begin errors++; $display("FAIL fault_count: got %0d want 2", fault_count); end
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL fault_fetch_count: got %0d want 3", fetch_count); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] got_pc [4];
        logic [31:0] got_instr [4];
        int n;
        n = 0;
        idle();
        load_en = 1'b1; load_addr = 32'h4; load_data = 32'h11111111;
        step();
        load_addr = 32'h8; load_data = 32'h22222222;
        step();
        load_en = 1'b0; req_valid = 1'b1; req_pc = 32'h0;
        step();
        req_pc = 32'h4;
        step();
        rsp_ready = 1'b0; req_pc = 32'h8;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready: cycle %0d got %b want 0", k, req_ready); end
            checks++; if (rsp_valid !== 1'b1 || rsp_pc !== 32'h0) begin errors++; $display("FAIL b2b_stall_hold: cycle %0d got valid=%b pc=%h want 1/0", k, rsp_valid, rsp_pc); end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_resume_ready: got %b want 1", req_ready); end
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid && rsp_ready) begin
                if (n < 4) begin got_pc[n] = rsp_pc; got_instr[n] = rsp_instr; end
                n++;
            end
            step();
            req_valid = 1'b0;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL b2b_count: got %0d responses want 3", n); end
        if (n >= 3) begin
            checks++; if (got_pc[0] !== 32'h0 || got_instr[0] !== 32'h00500093) begin errors++; $display("FAIL b2b_rsp0: got %h/%h want 0/00500093", got_pc[0], got_instr[0]); end
            checks++; if (got_pc[1] !== 32'h4 || got_instr[1] !== 32'h11111111) begin errors++; $display("FAIL b2b_rsp1: got %h/%h want 4/11111111", got_pc[1], got_instr[1]); end
            checks++; if (got_pc[2] !== 32'h8 || got_instr[2] !== 32'h22222222) begin errors++; $display("FAIL b2b_rsp2: got %h/%h want 8/22222222", got_pc[2], got_instr[2]); end
        end
        checks++; if (fetch_count !== 32'd6) begin errors++; $display("FAIL b2b_fetch_count: got %0d want 6", fetch_count); end
    endtask

    task automatic test_flush();
        idle();
        req_valid = 1'b1; req_pc = 32'h10;
        step();
        req_pc = 32'h14;
        step();
        req_valid = 1'b0; rsp_ready = 1'b0; flush = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", req_ready); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL flush_full: got rsp_valid=%b want 1", rsp_valid); end
        step();
        flush = 1'b0; rsp_ready = 1'b1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got rsp_valid=%b want 0", rsp_valid); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_stale: cycle %0d got rsp_valid=%b pc=%h want 0", k, rsp_valid, rsp_pc); end
        end
        checks++; if (fetch_count !== 32'd8) begin errors++; $display("FAIL flush_fetch_count: got %0d want 8", fetch_count); end
    endtask

    task automatic test_load_then_fetch();
        idle();
        load_en = 1'b1; load_addr = 32'hC; load_data = 32'hDEADBEEF;
        req_valid = 1'b1; req_pc = 32'hC;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ltf_load_ready: got %b want 0", req_ready); end
        step();
        load_en = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ltf_ready: got %b want 1", req_ready); end
        step();
        req_valid = 1'b0;
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_pc !== 32'hC) begin errors++; $display("FAIL ltf_rsp: got valid=%b pc=%h want 1/0000000c", rsp_valid, rsp_pc); end
        checks++; if (rsp_instr !== 32'hDEADBEEF) begin errors++; $display("FAIL ltf_instr: got %h want deadbeef", rsp_instr); end
        checks++; if (rsp_fault !== 2'b00) begin errors++; $display("FAIL ltf_fault: got %b want 00", rsp_fault); end
        step();
    endtask

    task automatic test_reset_midstream();
        idle();
        req_valid = 1'b1; req_pc = 32'h0;
        step();
        req_pc = 32'hC;
        step();
        req_valid = 1'b0; rst_n = 1'b0;
        step();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rm_ready: got %b want 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0 || rsp_instr !== 32'h0 || rsp_pc !== 32'h0 || rsp_fault !== 2'b00) begin
            errors++; $display("FAIL rm_outputs: got valid=%b instr=%h pc=%h fault=%b want all zero", rsp_valid, rsp_instr, rsp_pc, rsp_fault);
        end
        checks++; if (fetch_count !== 32'h0 || fault_count !== 16'h0) begin errors++; $display("FAIL rm_counters: got %0d/%0d want 0/0", fetch_count, fault_count); end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_stale: cycle %0d got rsp_valid=%b want 0", k, rsp_valid); end
        end
        req_valid = 1'b1; req_pc = 32'hC;
        step();
        req_valid = 1'b0;
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'hDEADBEEF) begin errors++; $display("FAIL rm_mem_kept: got valid=%b instr=%h want 1/deadbeef", rsp_valid, rsp_instr); end
        checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL rm_fetch_count: got %0d want 1", fetch_count); end
        step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            req_valid = ($urandom_range(0, 99) < 70);
            case ($urandom_range(0, 9))
                0:       req_pc = 32'($urandom_range(0, 63));
                1:       req_pc = ($urandom() & 32'hFFFF_FFFC) | 32'h0000_0100;
                default: req_pc = 32'($urandom_range(0, 15)) << 2;
            endcase
            rsp_ready = ($urandom_range(0, 99) < 75);
            flush     = ($urandom_range(0, 99) < 4);
            load_en   = ($urandom_range(0, 99) < 10);
            case ($urandom_range(0, 7))
                0:       load_addr = 32'($urandom_range(0, 63));
                1:       load_addr = 32'h0000_0100 | (32'($urandom_range(0, 15)) << 2);
                default: load_addr = 32'($urandom_range(0, 15)) << 2;
            endcase
            load_data = $urandom();
            #1;
            checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready: cycle %0d got %b want %b", k, req_ready, exp_ready()); end
            step();
            checks++; if (rsp_valid !== exp_rsp_valid()) begin errors++; $display("FAIL rnd_valid: cycle %0d got %b want %b", k, rsp_valid, exp_rsp_valid()); end
            if (exp_rsp_valid()) begin
                checks++;
                if (rsp_pc !== q[0].pc || rsp_instr !== q[0].instr || rsp_fault !== q[0].fault) begin
                    errors++;
                    $display("FAIL rnd_rsp: cycle %0d got pc=%h instr=%h fault=%b want pc=%h instr=%h fault=%b",
                             k, rsp_pc, rsp_instr, rsp_fault, q[0].pc, q[0].instr, q[0].fault);
                end
            end
            checks++; if (fetch_count !== m_fc) begin errors++; $display("FAIL rnd_fetch_count: cycle %0d got %0d want %0d", k, fetch_count, m_fc); end
            checks++; if (fault_count !== m_flc) begin errors++; $display("FAIL rnd_fault_count: cycle %0d got %0d want %0d", k, fault_count, m_flc); end
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
        q.delete();
        m_fc  = '0;
        m_flc = '0;
        rst_n = 1'b0;
        idle();
        test_reset();
        test_load_fetch();
        test_faults();
        test_back_to_back();
        test_flush();
        test_load_then_fetch();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_fetch_pipe.md
IMEM_FETCH_PIPE -- requirements
Module: imem_fetch_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of 32-bit instruction words; it SHALL be a power of 2 in the range 4..1024.
REQ-002 SHALL have parameter LAT, default 2, meaning read latency in cycles from request accept to response present; legal range 1..4.
REQ-003 SHALL have parameter NOP, default 32'h00000013, meaning the filler instruction returned on faults and held in unloaded words.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  1  fetch request present.
REQ-007 req_pc  input  32  byte address of the fetch.
REQ-008 req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  consumer takes the response this cycle.
REQ-011 rsp_instr  output  32  fetched instruction, or NOP on fault.
REQ-012 rsp_pc  output  32  req_pc of the request that produced this response.
REQ-013 rsp_fault  output  2  00 ok; 01 misaligned; 10 out of range; 11 unused.
REQ-014 flush  input  1  discards all in-flight fetches.
REQ-015 load_en  input  1  program-load write strobe.
REQ-016 load_addr  input  32  byte address of the load write.
REQ-017 load_data  input  32  word to write.
REQ-018 fetch_count  output  32  number of accepted requests.
REQ-019 fault_count  output  16  number of accepted requests that faulted.

Function
REQ-020 The word index SHALL be req_pc[log2(DEPTH)+1:2].
REQ-021 Misaligned SHALL be req_pc[1:0]!=0; it takes priority over out-of-range.
REQ-022 Out of range SHALL be req_pc[31:log2(DEPTH)+2]!=0.
REQ-023 On any fault, rsp_instr SHALL be NOP.
REQ-024 Pipeline: LAT stages; each stage holds valid, pc, instr and fault; the last stage drives the rsp_* outputs.
REQ-025 The advance condition SHALL be adv = !rsp_valid || rsp_ready; all stages shift together only when adv is high, and otherwise hold with no bubble collapse.
REQ-026 req_ready SHALL be adv && !flush && !load_en.
REQ-027 An accepted request SHALL appear on rsp_* exactly LAT cycles later when rsp_ready is held high, giving 1 response per cycle throughput.
REQ-028 A cycle with adv high and no accept SHALL insert a bubble (valid=0).
REQ-029 The memory array SHALL be read at accept; later loads SHALL NOT alter responses already in flight.
REQ-030 Flush SHALL clear every stage valid bit, including the output stage, at the next edge; rsp_valid SHALL be 0 the cycle after flush.
REQ-031 Load: when load_en is high and load_addr is aligned and in range, mem[load_addr index] SHALL take load_data at the edge.
REQ-032 A misaligned or out-of-range load SHALL be ignored silently.
REQ-033 A load SHALL take priority over fetch; no request is accepted in a load cycle.
REQ-034 A request accepted in the cycle after a load to the same word SHALL return the new data.
REQ-035 fetch_count SHALL increment by 1 per accept and wrap from 2^32-1 to 0.
REQ-036 fault_count SHALL increment per faulting accept and saturate at 16'hFFFF.
REQ-037 Flushed requests SHALL remain counted in both counters.
REQ-038 When flush and load_en are asserted together, both SHALL take effect.

Reset
REQ-039 While rst_n is low at an edge, all stage valid bits SHALL clear and the outputs SHALL become: rsp_valid=0, rsp_instr=0, rsp_pc=0, rsp_fault=0, fetch_count=0, fault_count=0.
REQ-040 req_ready SHALL be 0 while rst_n is low.
REQ-041 Memory contents SHALL be initialised to NOP at time zero and SHALL NOT be altered by reset.
REQ-042 Reset asserted mid-stream SHALL drop all in-flight fetches; no response for them SHALL appear after release.

Verification
REQ-043 LAT=2, load 0x00500093 at 0x0, then fetch pc=0x0 with rsp_ready=1 -> rsp_valid and rsp_instr=0x00500093 two cycles after accept, rsp_fault=00.
REQ-044 Fetch pc=0x2, then pc=0x100 with DEPTH=64 -> rsp_fault=01 then 10, rsp_instr=0x00000013 for both, fault_count=2.
REQ-045 Back-to-back fetches 0x0,0x4,0x8 with rsp_ready low for 3 cycles mid-stream -> req_ready low during the stall, responses in order, none lost or duplicated.
REQ-046 Flush with 2 fetches in flight -> rsp_valid=0 next cycle, no stale response later, fetch_count still counts both.
REQ-047 Load word 3 with 0xDEADBEEF and fetch pc=0xC in the next cycle -> 0xDEADBEEF; a fetch attempted during the load cycle -> req_ready=0.
REQ-048 Assert rst_n=0 for 1 cycle with the pipe full -> all outputs zero, counters zero, earlier loaded memory word still readable after release.
